spi_slave_scheduler: RTL

//  Shares the SPI slave byte datapath of spi_combine (tx_valid/tx_data, rx_valid/rx_data) among NUM_REQ host requesters.

---
 rtl/spi_slave_scheduler.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_scheduler
//  Purpose  : Shares the spi_combine slave byte datapath among NUM_REQ host
//             requesters. Writes SPCR once after reset, then loads one TX
//             byte per SPI frame (round-robin) and returns each received byte
//             tagged with the requester that owned the frame.
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave_scheduler #(
  parameter int         NUM_REQ   = 4,
  parameter int         IDW       = 2,
  parameter logic [1:0] SPCR_ADR  = 2'b00,
  parameter logic [7:0] SPCR_VAL  = 8'h83,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 rsp_valid_o,
  output logic [7:0]           rsp_data_o,
  output logic [IDW-1:0]       rsp_id_o,
  output logic                 rsp_owned_o,
  output logic                 err_drop_o,
  output logic                 busy_o,
  output logic                 cfg_stb_o,
  output logic                 cfg_we_o,
  output logic [1:0]           cfg_addr_o,
  output logic [7:0]           cfg_data_o,
  output logic                 core_tx_valid_o,
  output logic [7:0]           core_tx_data_o,
  input  logic                 core_rx_valid_i,
  input  logic [7:0]           core_rx_data_i,
  input  logic                 ssn_i
);

  typedef enum logic [1:0] {
    S_CFG  = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_owner;
  logic               r_owned;

  logic               r_ssn_meta;
  logic               r_ssn_sync;
  logic               r_ssn_dly;
  logic               w_ssn_rise;

  logic               w_grant_found;
  logic [IDW-1:0]     w_grant_id;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [IDW-1:0]     w_ptr_next;

  logic               r_rsp_valid;
  logic [7:0]         r_rsp_data;
  logic [IDW-1:0]     r_rsp_id;
  logic               r_rsp_owned;
  logic               r_err_drop;
  logic               r_busy;
  logic               r_cfg_stb;
  logic               r_cfg_we;
  logic [1:0]         r_cfg_addr;
  logic [7:0]         r_cfg_data;
  logic               r_tx_valid;
  logic [7:0]         r_tx_data;

  // Slave select is asynchronous to clk: two flops for metastability, a third
  // to detect the deasserting (rising) edge that aborts a frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ssn_meta <= 1'b1;
      r_ssn_sync <= 1'b1;
      r_ssn_dly  <= 1'b1;
    end else begin
      r_ssn_meta <= ssn_i;
      r_ssn_sync <= r_ssn_meta;
      r_ssn_dly  <= r_ssn_sync;
    end
  end

  assign w_ssn_rise = r_ssn_sync & ~r_ssn_dly;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_CFG;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, round-robin grant search from r_ptr and the one-hot ready.
  always_comb begin : p_next
    logic [IDW:0] v_sum;
    logic [IDW-1:0] v_id;
    w_state_next  = r_state;
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    w_req_ready   = '0;
    v_sum         = '0;
    v_id          = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_sum = {1'b0, r_ptr} + (IDW+1)'(i);
      if (v_sum >= (IDW+1)'(NUM_REQ)) begin
        v_sum = v_sum - (IDW+1)'(NUM_REQ);
      end
      v_id = v_sum[IDW-1:0];
      if (!w_grant_found && req_valid_i[v_id]) begin
        w_grant_found = 1'b1;
        w_grant_id    = v_id;
      end
    end
    case (r_state)
      S_CFG: begin
        w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_req_ready[w_grant_id] = w_grant_found;
        w_state_next            = S_WAIT;
      end
      S_WAIT: begin
        if (core_rx_valid_i || w_ssn_rise) begin
          w_state_next = S_LOAD;
        end
      end
      default: begin
        w_state_next = S_CFG;
      end
    endcase
  end

  assign w_ptr_next  = (w_grant_id == IDW'(NUM_REQ-1)) ? '0 : w_grant_id + IDW'(1);
  assign req_ready_o = w_req_ready;

  // Registered datapath: config write, TX load, response and abort reporting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_owned     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_owned <= 1'b0;
      r_err_drop  <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_stb   <= 1'b0;
      r_cfg_we    <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_cfg_stb   <= 1'b0;
      r_cfg_we    <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_tx_valid  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_err_drop  <= 1'b0;
      r_busy      <= (w_state_next == S_CFG) || (w_state_next == S_WAIT);
      case (r_state)
        S_CFG: begin
          r_cfg_stb  <= 1'b1;
          r_cfg_we   <= 1'b1;
          r_cfg_addr <= SPCR_ADR;
          r_cfg_data <= SPCR_VAL;
        end
        S_LOAD: begin
          r_tx_valid <= 1'b1;
          if (w_grant_found) begin
            r_tx_data <= req_data_i[{w_grant_id, 3'b000} +: 8];
            r_owner   <= w_grant_id;
            r_owned   <= 1'b1;
            r_ptr     <= w_ptr_next;
          end else begin
            r_tx_data <= IDLE_BYTE;
            r_owner   <= '0;
            r_owned   <= 1'b0;
          end
        end
        S_WAIT: begin
          // A completed frame takes precedence over a simultaneous abort.
          if (core_rx_valid_i) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= core_rx_data_i;
            r_rsp_id    <= r_owner;
            r_rsp_owned <= r_owned;
          end else if (w_ssn_rise) begin
            r_err_drop <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_valid_o     = r_rsp_valid;
  assign rsp_data_o      = r_rsp_data;
  assign rsp_id_o        = r_rsp_id;
  assign rsp_owned_o     = r_rsp_owned;
  assign err_drop_o      = r_err_drop;
  assign busy_o          = r_busy;
  assign cfg_stb_o       = r_cfg_stb;
  assign cfg_we_o        = r_cfg_we;
  assign cfg_addr_o      = r_cfg_addr;
  assign cfg_data_o      = r_cfg_data;
  assign core_tx_valid_o = r_tx_valid;
  assign core_tx_data_o  = r_tx_data;

endmodule
`default_nettype wire
